// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART character receiver.
// UART_RX_PARITY_EN adds the parity state encoding.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef logic [2:0] state_t;

    localparam state_t StIdle     = 3'd0;
    localparam state_t StStart    = 3'd1;
    localparam state_t StData     = 3'd2;
    localparam state_t StStop     = 3'd3;
    localparam state_t StWaitIdle = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam state_t StParity   = 3'd5;
`endif

    // Rounded clocks per oversample tick.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned per_tick;
        per_tick = baud * oversample;
        return (clk_hz + per_tick / 2) / per_tick;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider; restart_i zeroes the phase so ticks align to a start edge.
module uart_baud_tick #(
    parameter int unsigned Div = 27
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || cnt_q == CntLast) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CntLast);

endmodule

// File: rtl/uart_rx_char.sv
// UART character receiver with Nios-style level flag and edge acknowledge.
// Define UART_RX_PARITY_EN to receive 8E1/8O1 frames and report parity_error.
module uart_rx_char
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 char_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 char_received,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 parity_error
);

    localparam int unsigned Div  = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned SubW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW = $clog2(DATA_BITS);
    localparam logic [SubW-1:0] SubMid  = SubW'(OVERSAMPLE / 2 - 1);
    localparam logic [SubW-1:0] SubLast = SubW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic ack_q, ack_prev_q;
    state_t state_q, state_d;
    logic [SubW-1:0] sub_q, sub_d;
    logic [BitW-1:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic char_received_q, char_received_d;
    logic framing_error_q, framing_error_d;
    logic overrun_q, overrun_d;

    logic tick, fall, mid_tick, restart, accept, accept_load, frame_err, ack_edge;

    assign fall     = rx_prev_q & ~rx_sync_q;
    assign ack_edge = ack_q & ~ack_prev_q;
    assign mid_tick = tick && (sub_q == ((state_q == StStart) ? SubMid : SubLast));

    uart_baud_tick #(
        .Div(Div)
    ) u_baud_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .restart_i(restart),
        .tick_o   (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic parity_error_q, parity_error_d;
    logic par_fail;
`endif

    always_comb begin
        state_d   = state_q;
        sub_d     = sub_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        restart   = 1'b0;
        accept    = 1'b0;
        frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_fail  = 1'b0;
`endif
        if (tick) begin
            sub_d = mid_tick ? '0 : sub_q + 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    sub_d   = '0;
                    restart = 1'b1;
                end
            end
            StStart: begin
                if (mid_tick) begin
                    // A line back high at mid-bit is a glitch, not a start bit.
                    state_d = rx_sync_q ? StIdle : StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (mid_tick) begin
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (mid_tick) begin
                    par_fail = ((^shift_q) ^ rx_sync_q) != PARITY_ODD;
                    state_d  = StStop;
                end
            end
`endif
            StStop: begin
                if (mid_tick) begin
                    if (rx_sync_q) begin
                        accept  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = StWaitIdle;
                    end
                end
            end
            StWaitIdle: begin
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // An ack edge in the accept cycle frees the slot, so the new byte is not an overrun.
    assign accept_load = accept & (~char_received_q | ack_edge);

    always_comb begin
        rx_data_d       = accept_load ? shift_q : rx_data_q;
        char_received_d = accept_load | (char_received_q & ~ack_edge);
        framing_error_d = frame_err | (framing_error_q & ~ack_edge);
        overrun_d       = (accept & char_received_q & ~ack_edge) | (overrun_q & ~ack_edge);
`ifdef UART_RX_PARITY_EN
        parity_error_d  = par_fail | (parity_error_q & ~ack_edge);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q       <= 1'b1;
            rx_sync_q       <= 1'b1;
            rx_prev_q       <= 1'b1;
            ack_q           <= 1'b0;
            ack_prev_q      <= 1'b0;
            state_q         <= StIdle;
            sub_q           <= '0;
            bit_q           <= '0;
            shift_q         <= '0;
            rx_data_q       <= '0;
            char_received_q <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            rx_meta_q       <= rx;
            rx_sync_q       <= rx_meta_q;
            rx_prev_q       <= rx_sync_q;
            ack_q           <= char_ack;
            ack_prev_q      <= ack_q;
            state_q         <= state_d;
            sub_q           <= sub_d;
            bit_q           <= bit_d;
            shift_q         <= shift_d;
            rx_data_q       <= rx_data_d;
            char_received_q <= char_received_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_error_q <= 1'b0;
        end else begin
            parity_error_q <= parity_error_d;
        end
    end
    assign parity_error = parity_error_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
    assign parity_error      = 1'b0;
`endif

    assign rx_data       = rx_data_q;
    assign char_received = char_received_q;
    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_char.sv
// Scoreboard bench for uart_rx_char: expected bytes queued per frame, popped on delivery.
module tb_uart_rx_char;

    localparam int unsigned ClkHz   = 50_000_000;
    localparam int unsigned Baud    = 115200;
    localparam int unsigned Os      = 16;
    localparam int unsigned BitClks = 432;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       char_ack = 1'b0;
    logic [7:0] rx_data;
    logic       char_received, framing_error, overrun, parity_error;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    int unsigned last_evt_cyc = 0;
    logic        prev_cr = 1'b0;
    logic [7:0]  prev_data = 8'h00;
`ifdef UART_RX_PARITY_EN
    logic        bad_parity = 1'b0;
`endif

    uart_rx_char #(
        .CLK_HZ    (ClkHz),
        .BAUD      (Baud),
        .OVERSAMPLE(Os),
        .PARITY_ODD(1'b0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .char_ack     (char_ack),
        .rx_data      (rx_data),
        .char_received(char_received),
        .framing_error(framing_error),
        .overrun      (overrun),
        .parity_error (parity_error)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Delivery is a char_received rise, or a new byte landing while it stays high.
    always @(negedge clk) begin
        if (reset_n && char_received && (!prev_cr || rx_data != prev_data)) begin
            last_evt_cyc <= cyc;
            check_value("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_value("sb_rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        prev_cr   <= char_received;
        prev_data <= rx_data;
    end

    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input int unsigned stop_bits);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        rx = 1'b0;
        repeat (BitClks) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (BitClks) @(posedge clk);
            #1;
        end
`ifdef UART_RX_PARITY_EN
        rx = (^data) ^ bad_parity;
        repeat (BitClks) @(posedge clk);
        #1;
`endif
        rx = stop_val;
        repeat (BitClks * stop_bits) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (BitClks) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        @(posedge clk);
        #1;
        char_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        char_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic cr, input logic fe, input logic ov);
        @(negedge clk);
        check_value({tag, "_char_received"}, 32'(char_received), 32'(cr));
        check_value({tag, "_framing_error"}, 32'(framing_error), 32'(fe));
        check_value({tag, "_overrun"}, 32'(overrun), 32'(ov));
    endtask

    task automatic check_drained(input string tag);
        check_value({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_value("reset_rx_data", 32'(rx_data), 32'h00);
        check_value("reset_parity_error", 32'(parity_error), 32'd0);
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);

        // Basic receive with latency window.
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1, 1);
        check_drained("basic");
        check_value("basic_latency_ok",
                    32'((last_evt_cyc - start_cyc) >= 4080 && (last_evt_cyc - start_cyc) <= 4134),
                    32'd1);
        check_value("basic_parity_error", 32'(parity_error), 32'd0);
        check_flags("basic", 1'b1, 1'b0, 1'b0);
        pulse_ack();
        check_flags("basic_ack", 1'b0, 1'b0, 1'b0);

        // Short low pulse must not start a frame.
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * BitClks) @(posedge clk);
        check_flags("glitch", 1'b0, 1'b0, 1'b0);
        check_value("glitch_rx_data", 32'(rx_data), 32'h41);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1);
        check_drained("after_glitch");
        pulse_ack();

        // Stop bit held low for two bit times.
        send_frame(8'h33, 1'b0, 2);
        check_flags("framing", 1'b0, 1'b1, 1'b0);
        check_value("framing_rx_data", 32'(rx_data), 32'h5A);
        exp_q.push_back(8'h34);
        send_frame(8'h34, 1'b1, 1);
        check_drained("after_framing");
        check_flags("after_framing", 1'b1, 1'b1, 1'b0);
        pulse_ack();
        check_flags("framing_ack", 1'b0, 1'b0, 1'b0);

        // Second byte without ack is dropped.
        exp_q.push_back(8'h61);
        send_frame(8'h61, 1'b1, 1);
        send_frame(8'h62, 1'b1, 1);
        check_drained("overrun");
        check_value("overrun_rx_data", 32'(rx_data), 32'h61);
        check_flags("overrun", 1'b1, 1'b0, 1'b1);
        pulse_ack();
        check_flags("overrun_ack", 1'b0, 1'b0, 1'b0);
        check_value("overrun_ack_rx_data", 32'(rx_data), 32'h61);
        exp_q.push_back(8'h63);
        send_frame(8'h63, 1'b1, 1);
        check_drained("after_overrun");
        check_value("after_overrun_rx_data", 32'(rx_data), 32'h63);

        // Ack edge lands in the accept cycle: 4105 edges after the rx fall edge.
        exp_q.push_back(8'h7A);
        fork
            send_frame(8'h7A, 1'b1, 1);
            begin
                @(posedge clk);
                repeat (4105) @(posedge clk);
                #1;
                char_ack = 1'b1;
            end
        join
        check_drained("ack_accept");
        check_value("ack_accept_rx_data", 32'(rx_data), 32'h7A);
        check_flags("ack_accept", 1'b1, 1'b0, 1'b0);
        char_ack = 1'b0;
        repeat (4) @(posedge clk);

        // Reset during bit 4 of a partial frame.
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (BitClks) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            rx = i[0] ? 1'b0 : 1'b1;
            repeat (BitClks) @(posedge clk);
        end
        repeat (BitClks / 2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("midreset_rx_data", 32'(rx_data), 32'h00);
        check_value("midreset_parity_error", 32'(parity_error), 32'd0);
        check_flags("midreset", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2 * BitClks) @(posedge clk);
        check_flags("post_reset", 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'h48);
        send_frame(8'h48, 1'b1, 1);
        check_drained("post_reset");
        check_value("post_reset_rx_data", 32'(rx_data), 32'h48);

`ifdef UART_RX_PARITY_EN
        pulse_ack();
        bad_parity = 1'b1;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1);
        bad_parity = 1'b0;
        check_drained("parity");
        @(negedge clk);
        check_value("parity_error_set", 32'(parity_error), 32'd1);
        check_value("parity_rx_data", 32'(rx_data), 32'h07);
        check_flags("parity", 1'b1, 1'b0, 1'b0);
`endif

        check_drained("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
